// File: rtl/spi_tx_pkg.sv
// spi_tx_pkg: shared definitions for the SPI transmit queue.
//   - entry layout (width and flag bit positions)
//   - launch FSM state encoding
//   - packed view of a queued entry
package spi_tx_pkg;

    localparam int SPI_ENTRY_W = 10;
    localparam int SPI_DC_BIT  = 9;
    localparam int SPI_END_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_SETTLE = 2'd2
    } spi_tx_state_e;

    // Field order matches the bus word: [9]=dc, [8]=end_txn, [7:0]=byte.
    typedef struct packed {
        logic       dc;
        logic       end_txn;
        logic [7:0] data;
    } spi_entry_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: generic synchronous FIFO (circular buffer + occupancy count).
//   clk, rstn      : clock, asynchronous active-low reset
//   push_i         : write strobe; ignored (and flagged on drop_o) when full
//   wr_data_i      : entry to write
//   pop_i          : read strobe; ignored when empty
//   rd_data_o      : head entry (valid while !empty_o)
//   full_o/empty_o : occupancy flags
//   level_o        : occupied entries, 0..DEPTH
//   drop_o         : a push was rejected this cycle because the FIFO was full
// A push into a full FIFO is dropped even if a pop happens in the same cycle;
// the full check uses the registered count only.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic             drop_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign drop_o  = push_i && full_o;

    // Pointers are exactly log2(DEPTH) bits, so increments wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only visible through level/pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/spi_tx_queue.sv
// spi_tx_queue: buffers bus writes to the SPI data register and launches them
// into spi_ctrl back-to-back whenever the controller is idle.
//   clk, rstn    : clock, asynchronous active-low reset
//   wr_en        : push strobe; wr_data = {dc, end_txn, byte}
//   clr_overflow : clears the sticky overflow flag (wins over a same-cycle set)
//   spi_busy     : busy from spi_ctrl
//   spi_start    : one-cycle start pulse; spi_byte/spi_end_txn/spi_dc valid with it
//   full, level  : queue occupancy
//   idle         : queue empty, FSM idle and spi_busy low (software status bit)
//   overflow     : sticky, a push was dropped
// Launch FSM: IDLE -> LAUNCH (pop head into output regs) -> SETTLE -> IDLE.
// SETTLE skips one cycle so spi_ctrl's registered busy has time to rise.
module spi_tx_queue
    import spi_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [SPI_ENTRY_W-1:0] wr_data,
    input  logic                   clr_overflow,
    input  logic                   spi_busy,
    output logic                   spi_start,
    output logic [7:0]             spi_byte,
    output logic                   spi_end_txn,
    output logic                   spi_dc,
    output logic                   full,
    output logic [LVL_W-1:0]       level,
    output logic                   idle,
    output logic                   overflow
);

    spi_tx_state_e          state_q;
    logic [SPI_ENTRY_W-1:0] head_raw;
    spi_entry_t             head;
    logic                   empty;
    logic                   drop;
    logic                   launch;
    logic                   start_q;
    logic [7:0]             byte_q;
    logic                   end_q;
    logic                   dc_q;
    logic                   overflow_q, overflow_d;

    assign head   = spi_entry_t'(head_raw);
    assign launch = (state_q == ST_IDLE) && !empty && !spi_busy;

    byte_fifo #(
        .WIDTH (SPI_ENTRY_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (launch),
        .rd_data_o (head_raw),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level),
        .drop_o    (drop)
    );

    // Launch FSM with registered start pulse and payload registers. The
    // payload holds its last value between launches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            byte_q  <= '0;
            end_q   <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q <= ST_LAUNCH;
                        start_q <= 1'b1;
                        byte_q  <= head.data;
                        end_q   <= head.end_txn;
                        dc_q    <= head.dc;
                    end
                end
                ST_LAUNCH: state_q <= ST_SETTLE;
                ST_SETTLE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow)  overflow_d = 1'b0;
        else if (drop)     overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign spi_start   = start_q;
    assign spi_byte    = byte_q;
    assign spi_end_txn = end_q;
    assign spi_dc      = dc_q;
    assign overflow    = overflow_q;
    assign idle        = empty && (state_q == ST_IDLE) && !spi_busy;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue: inputs change 1 time unit after the rising
// edge, outputs are sampled at the same point.
module tb_spi_tx_queue;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr_en;
    logic [9:0] wr_data;
    logic       clr_overflow;
    logic       spi_busy;
    logic       spi_start;
    logic [7:0] spi_byte;
    logic       spi_end_txn;
    logic       spi_dc;
    logic       full;
    logic [2:0] level;
    logic       idle;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] got_byte [16];
    logic       got_end  [16];
    int         got_n;

    always #5 clk = ~clk;

    spi_tx_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .spi_busy     (spi_busy),
        .spi_start    (spi_start),
        .spi_byte     (spi_byte),
        .spi_end_txn  (spi_end_txn),
        .spi_dc       (spi_dc),
        .full         (full),
        .level        (level),
        .idle         (idle),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    // Acts as spi_ctrl: raises busy on each start and drops it two cycles later.
    task automatic drain(input int max_cyc);
        int bcnt;
        bcnt     = 0;
        got_n    = 0;
        spi_busy = 1'b0;
        repeat (max_cyc) begin
            tick();
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) spi_busy = 1'b0;
            end
            if (spi_start) begin
                if (got_n < 16) begin
                    got_byte[got_n] = spi_byte;
                    got_end[got_n]  = spi_end_txn;
                end
                got_n++;
                spi_busy = 1'b1;
                bcnt     = 2;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] vals [4];
        int         n_starts;
        int         last_cyc;
        int         min_gap;

        rstn = 1'b0; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0; spi_busy = 1'b0;
        repeat (3) tick();
        chk("rst_start",    spi_start, 0);
        chk("rst_byte",     spi_byte,  0);
        chk("rst_end",      spi_end_txn, 0);
        chk("rst_dc",       spi_dc,    0);
        chk("rst_level",    level,     0);
        chk("rst_full",     full,      0);
        chk("rst_overflow", overflow,  0);
        chk("rst_idle",     idle,      1);
        rstn = 1'b1;
        tick();

        // Single byte latency.
        push(10'h2A0);
        chk("t1_start_n",   spi_start, 0);
        chk("t1_level_n",   level,     1);
        tick();
        chk("t1_start_n1",  spi_start, 1);
        chk("t1_byte",      spi_byte,  8'hA0);
        chk("t1_dc",        spi_dc,    1);
        chk("t1_end",       spi_end_txn, 0);
        chk("t1_level_n1",  level,     0);
        tick();
        chk("t1_start_off", spi_start, 0);
        tick();
        chk("t1_idle",      idle,      1);

        // Fill while busy, then drain in order.
        vals[0] = 10'h011; vals[1] = 10'h022; vals[2] = 10'h033; vals[3] = 10'h144;
        spi_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(vals[i]);
        chk("t2_full",  full,  1);
        chk("t2_level", level, 4);
        chk("t2_idle",  idle,  0);
        drain(16);
        chk("t2_count", got_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_byte%0d", i), got_byte[i], vals[i][7:0]);
            chk($sformatf("t2_end%0d", i),  got_end[i],  (i == 3) ? 1 : 0);
        end
        chk("t2_level_end", level, 0);

        // Overflow on full, then clear winning over a same-cycle drop.
        spi_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(10'h0B0 + 10'(i));
        push(10'h055);
        chk("t3_level", level,    4);
        chk("t3_ovf",   overflow, 1);
        clr_overflow = 1'b1;
        push(10'h077);
        clr_overflow = 1'b0;
        chk("t3_clr_ovf",   overflow, 0);
        chk("t3_clr_level", level,    4);

        // Pop and dropped push in the same cycle.
        spi_busy = 1'b0;
        push(10'h066);
        spi_busy = 1'b1;
        chk("t4_start", spi_start, 1);
        chk("t4_byte",  spi_byte,  8'hB0);
        chk("t4_level", level,     3);
        chk("t4_ovf",   overflow,  1);
        drain(16);
        chk("t4_count", got_n, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t4_byte%0d", i), got_byte[i], 8'hB1 + 8'(i));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t4_ovf_clr", overflow, 0);

        // Wrap-around: 7 entries with free-running launches.
        spi_busy = 1'b0;
        n_starts = 0;
        last_cyc = -100;
        min_gap  = 1000;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    push(10'h070 + 10'(i));
                    tick();
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    tick();
                    if (spi_start) begin
                        if (n_starts < 16) got_byte[n_starts] = spi_byte;
                        if (c - last_cyc < min_gap) min_gap = c - last_cyc;
                        last_cyc = c;
                        n_starts++;
                    end
                end
            end
        join
        chk("t5_count", n_starts, 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t5_byte%0d", i), got_byte[i], 8'h70 + 8'(i));
        chk("t5_gap_ge3", (min_gap >= 3) ? 1 : 0, 1);
        chk("t5_ovf",     overflow, 0);
        chk("t5_level",   level,    0);

        // Reset during LAUNCH with 2 entries still queued.
        spi_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(10'h0C0 + 10'(i));
        spi_busy = 1'b0;
        tick();
        chk("t6_start",  spi_start, 1);
        chk("t6_level",  level,     2);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_start", spi_start, 0);
        chk("t6_async_level", level,     0);
        chk("t6_async_byte",  spi_byte,  0);
        tick();
        tick();
        rstn = 1'b1;
        n_starts = 0;
        repeat (10) begin
            tick();
            if (spi_start) n_starts++;
        end
        chk("t6_no_starts", n_starts, 0);
        chk("t6_level_end", level,    0);
        chk("t6_idle",      idle,     1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_tx_queue.md
# spi_tx_queue

Transmit queue between the memory-mapped peripheral decode and `spi_ctrl`. It buffers bus writes to the SPI data register, each holding a byte plus `dc` and `end_txn` flags, and launches them into `spi_ctrl` back-to-back whenever the controller is idle. This lets the core post several bytes without polling `spi_busy` between them.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `LVL_W`, $clog2(DEPTH)+1: width of `level`.

- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  one-cycle push strobe: bus write to the SPI data address.
- `wr_data`  in  10  entry to push: [9]=dc, [8]=end_txn, [7:0]=byte.
- `clr_overflow`  in  1  clears the sticky `overflow` flag.
- `spi_busy`  in  1  busy from `spi_ctrl`.
- `spi_start`  out  1  one-cycle start pulse to `spi_ctrl`.
- `spi_byte`  out  8  byte for `spi_ctrl`; valid while `spi_start` is high.
- `spi_end_txn`  out  1  end_txn for `spi_ctrl`; valid while `spi_start` is high.
- `spi_dc`  out  1  dc for `spi_ctrl`; valid while `spi_start` is high.
- `full`  out  1  `level == DEPTH`.
- `level`  out  LVL_W  occupied entries (0..DEPTH).
- `idle`  out  1  queue empty, FSM in IDLE and `spi_busy` low; software polls this as the status bit.
- `overflow`  out  1  sticky flag: a push was dropped.

## Operation
- Circular buffer with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- Push: if `wr_en` and not `full`, write the entry at the write pointer, then advance it.
- `wr_en` while `full` drops the entry and sets `overflow`. This holds even if a pop happens in the same cycle.
- A pop and an accepted push in the same cycle leave `level` unchanged.
- The FSM is a registered 2-bit state: IDLE, LAUNCH, SETTLE.
  - IDLE → LAUNCH when `level != 0` and `spi_busy == 0`. On this transition, pop the head into the output registers `spi_byte`, `spi_end_txn` and `spi_dc`.
  - LAUNCH: `spi_start = 1` for exactly this cycle. Always goes to SETTLE.
  - SETTLE: `spi_busy` is ignored for this one cycle to cover `spi_ctrl`'s registered busy. Always goes to IDLE.
- Output registers hold their last value when not launching. `spi_ctrl` samples them only on `spi_start`.
- `clr_overflow` has priority over a same-cycle overflow set: the flag clears.
- Arithmetic: `level` is LVL_W bits and never exceeds DEPTH or goes below 0. Pointers are $clog2(DEPTH) bits with natural wrap.

## Timing
- Reset values:
  - `spi_start` 0.
  - `spi_byte`, `spi_end_txn`, `spi_dc` all 0.
  - `level` 0, `full` 0, `overflow` 0.
  - State IDLE, pointers 0.
  - `idle` is 1 once `spi_busy` is low.
- Reset asserted mid-operation discards all queued entries and any pending launch. `spi_start` drops to 0 asynchronously.
- Latency from a push into an empty queue with `spi_busy` low:
  - `wr_en` is sampled at edge N.
  - IDLE→LAUNCH at edge N+1.
  - `spi_start` is high during cycle N+1..N+2.
  - No combinational bypass from `wr_data` to the outputs.
- Minimum spacing between consecutive `spi_start` pulses is 3 cycles. In practice it is set by `spi_busy`.
- `full`, `level` and `idle` are combinational from registers. They update the cycle after a push or pop.
- `spi_busy` rising during IDLE with a non-empty queue blocks the launch until it falls.

## Structure
- Package `spi_tx_pkg`:
  - `SPI_ENTRY_W = 10`
  - bit indices `SPI_DC_BIT = 9`, `SPI_END_BIT = 8`
  - state encoding constants.
- Sub-module `byte_fifo`: a generic synchronous FIFO with parameters `WIDTH` and `DEPTH`, outputs `full`, `empty` and `level`, and the drop-on-full rule.
- `spi_tx_queue` instantiates `byte_fifo` with WIDTH=10 and adds the FSM, output registers and overflow flag.

## Test plan
- Reset, then push 0x2A0 with `spi_busy` low → `spi_start` pulses exactly 2 cycles after `wr_en`, with `spi_byte`=0xA0, `spi_dc`=1, `spi_end_txn`=0; `level` returns to 0 and `idle`=1.
- Hold `spi_busy`=1 and push 0x011, 0x022, 0x033, 0x144 → `full`=1 and `level`=4. Release busy, re-asserting it 1 cycle after each start for 16 cycles → 4 starts in order 11, 22, 33, 44; only the last has `spi_end_txn`=1.
- Full queue with busy high, push 0x055 → `level` stays 4 and `overflow`=1. Then assert `clr_overflow` and a dropped push in the same cycle → `overflow`=0.
- Full queue, with an IDLE→LAUNCH pop and a `wr_en` of 0x066 in the same cycle → 0x066 dropped, `overflow`=1, `level`=3.
- Wrap-around: push and drain 7 entries through DEPTH=4 → order preserved and pointers wrap cleanly.
- Deassert `rstn` during LAUNCH with 2 entries queued → `spi_start` drops immediately. After release, `level`=0 and no further starts occur.
